fetch_queue: RTL and testbench

- Decoupling instruction buffer between the fetch stage (IF) and decode (ID).
- Enqueues each fetched {pc, instr} presented by IF and dequeues in order to ID over a valid/ready handshake.
- Drives IF's stall input when it has no room, so that IF holds its fetch buffer without losing or duplicating instructions.
- Flushes all contents on a misprediction redirect, in the same cycle IF is flushed.

---
 rtl/general_defines.sv | 15 +
 rtl/fetch_queue.sv | 73 +++++++
 tb/tb_fetch_queue.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/general_defines.sv
// Shared core widths and fetch/decode bundle types.
// Imported by the pipeline stages and the fetch queue.
package general_defines;

  localparam int INSTR_MEM_IDX_W = 10;
  localparam int INT_DATA_W      = 32;

  localparam int FETCH_Q_DEPTH = 4;

  typedef struct packed {
    logic [INSTR_MEM_IDX_W-1:0] pc;
    logic [INT_DATA_W-1:0]      instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Decoupling buffer between IF and ID.
// Stalls IF when full; flushed with IF on redirect.
module fetch_queue
  import general_defines::*;
#(
  parameter int DEPTH = FETCH_Q_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [INSTR_MEM_IDX_W-1:0] in_pc,
  input  logic [INT_DATA_W-1:0]      in_instr,
  output logic                       fetch_stall,
  output logic                       out_valid,
  output logic [INSTR_MEM_IDX_W-1:0] out_pc,
  output logic [INT_DATA_W-1:0]      out_instr,
  input  logic                       out_ready,
  output logic [PTR_W:0]             occupancy
);

  fetch_entry_t     mem [DEPTH];
  fetch_entry_t     head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             enq;
  logic             deq;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  // Stall depends on the count register only, never on this cycle's inputs.
  assign fetch_stall = full;

  assign enq = in_valid && !fetch_stall && !flush;
  assign deq = out_valid && out_ready && !flush;

  assign head      = mem[rd_ptr];
  assign out_valid = !empty;
  assign out_pc    = empty ? '0 : head.pc;
  assign out_instr = empty ? '0 : head.instr;
  assign occupancy = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (deq) rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      unique case (1'b1)
        enq && !deq: count <= (PTR_W+1)'(count + 1'b1);
        deq && !enq: count <= (PTR_W+1)'(count - 1'b1);
        default:     count <= count;
      endcase
    end
  end

  // Storage is not reset; empty slots are masked at the outputs.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue.
// Checks every cycle against a queue-based model.
module tb_fetch_queue;
  import general_defines::*;

  localparam int DEPTH = FETCH_Q_DEPTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int PW    = INSTR_MEM_IDX_W;
  localparam int IW    = INT_DATA_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [PW-1:0] in_pc = '0;
  logic [IW-1:0] in_instr = '0;
  logic          fetch_stall;
  logic          out_valid;
  logic [PW-1:0] out_pc;
  logic [IW-1:0] out_instr;
  logic          out_ready = 1'b0;
  logic [PTR_W:0] occupancy;

  int errors = 0;
  int checks = 0;

  logic [PW+IW-1:0] q[$];
  int unsigned      obs[$];

  fetch_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .fetch_stall(fetch_stall), .out_valid(out_valid),
    .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO of {pc,instr}, flush empties it, stall when DEPTH held.
  always @(posedge clk or posedge rst) begin
    if (rst) q.delete();
    else if (flush) q.delete();
    else begin
      automatic bit e = in_valid && (q.size() < DEPTH);
      automatic bit d = (q.size() > 0) && out_ready;
      if (d) void'(q.pop_front());
      if (e) q.push_back({in_pc, in_instr});
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      automatic int sz = q.size();
      automatic logic [PW-1:0] epc = (sz > 0) ? q[0][PW+IW-1:IW] : '0;
      automatic logic [IW-1:0] ein = (sz > 0) ? q[0][IW-1:0] : '0;
      automatic logic [PTR_W-1:0] diff = dut.wr_ptr - dut.rd_ptr;
      chk("out_valid", out_valid, sz > 0);
      chk("fetch_stall", fetch_stall, sz == DEPTH);
      chk("occupancy", occupancy, sz);
      chk("out_pc", out_pc, epc);
      chk("out_instr", out_instr, ein);
      chk("ptr_invariant", diff, sz % DEPTH);
      if (out_valid && out_ready && !flush) obs.push_back(out_pc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int pc, int ins);
    in_valid = 1'b1;
    in_pc    = PW'(pc);
    in_instr = IW'(ins);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      step();
      n++;
    end
    out_ready = 1'b0;
    chk("drain_done", q.size(), 0);
  endtask

  initial begin
    int nxt;
    int n;
    bit acc;
    bit drop;
    logic [PW-1:0] pc_ctr;

    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stall", fetch_stall, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    step();
    rst = 1'b0;
    step();

    // Empty latency
    in_valid = 1'b1; in_pc = 5; in_instr = 32'hABCD;
    #1;
    chk("lat_before", out_valid, 0);
    step();
    in_valid = 1'b0;
    chk("lat_valid", out_valid, 1);
    chk("lat_pc", out_pc, 5);
    chk("lat_instr", out_instr, 32'hABCD);
    drain();

    // Fill
    for (int i = 0; i < 4; i++) begin
      push(i, 'h100 + i);
      chk("fill_occ", occupancy, i + 1);
      chk("fill_head", out_pc, 0);
    end
    chk("fill_stall", fetch_stall, 1);
    in_valid = 1'b1; in_pc = 4; in_instr = 'h104;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_hold_occ", occupancy, 4);
      chk("full_hold_head", out_pc, 0);
    end

    // Drain with wrap while IF resumes pc 4..9
    obs.delete();
    out_ready = 1'b1;
    nxt = 4;
    n = 0;
    while ((in_valid || q.size() > 0) && n < 40) begin
      acc = in_valid && (q.size() < DEPTH);
      step();
      if (n == 0) chk("stall_drop", fetch_stall, 0);
      if (acc) begin
        nxt++;
        in_valid = (nxt <= 9);
        in_pc = PW'(nxt);
        in_instr = IW'('h100 + nxt);
      end
      n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("wrap_count", obs.size(), 10);
    for (int i = 0; i < 10; i++)
      if (i < obs.size()) chk("wrap_order", obs[i], i);

    // Simultaneous enq/deq at occupancy 2
    push(30, 'h130);
    push(31, 'h131);
    obs.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_pc = PW'(32 + i); in_instr = IW'('h132 + i);
      step();
      chk("simul_occ", occupancy, 2);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("simul_count", obs.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < obs.size()) chk("simul_order", obs[i], 30 + i);
    drain();

    // Flush with traffic
    push(40, 1); push(41, 2); push(42, 3);
    obs.delete();
    flush = 1'b1; in_valid = 1'b1; in_pc = 7; in_instr = 7; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_occ", occupancy, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_stall", fetch_stall, 0);
    push(20, 'h20);
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_pc", out_pc, 20);
    drain();
    chk("flush_obs_count", obs.size(), 1);
    if (obs.size() > 0) chk("flush_obs_pc", obs[0], 20);

    // Random traffic
    pc_ctr = 100;
    for (int k = 0; k < 3000; k++) begin
      acc  = in_valid && (q.size() < DEPTH) && !flush;
      drop = acc || flush || !in_valid;
      step();
      if (drop) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_pc    = pc_ctr;
        in_instr = $urandom;
        pc_ctr++;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();

    // Async reset mid-run with 3 entries held
    drain();
    push(1, 1); push(2, 2); push(3, 3);
    chk("pre_rst_occ", occupancy, 3);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_stall", fetch_stall, 0);
    step();
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
